// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with format report and a
// 2-entry skid buffer: valid/ready in, {imm, fmt, inst} out one cycle later.
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_inst instruction word
//   out_valid/out_ready  downstream handshake
//   out_imm              XLEN-bit extended immediate
//   out_fmt              0 I, 1 S, 2 B, 3 U, 4 J, 5 Z, 7 NONE
//   out_inst             instruction word that produced out_imm
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_Z    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  logic [6:0]      opc;
  logic            is_i, is_s, is_b, is_u, is_j, is_z;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic [2:0]      main_fmt_q, main_fmt_d;
  logic [31:0]     main_inst_q, main_inst_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic [31:0]     skid_inst_q, skid_inst_d;

  logic accept, drain;

  assign opc = in_inst[6:0];

  always_comb begin
    is_i = (opc == 7'b0000011) || (opc == 7'b0001111) ||
           (opc == 7'b0010011) || (opc == 7'b1100111) ||
           ((opc == 7'b0011011) && (XLEN == 64)) ||
           ((opc == 7'b1110011) && !in_inst[14]);
    is_z = (opc == 7'b1110011) && in_inst[14];
    is_s = (opc == 7'b0100011);
    is_b = (opc == 7'b1100011);
    is_u = (opc == 7'b0110111) || (opc == 7'b0010111);
    is_j = (opc == 7'b1101111);
  end

  // Size casts of $signed operands sign-extend to XLEN.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    unique case (1'b1)
      is_i: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_inst[31:20]));
      end
      is_s: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      is_b: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[7],
                                 in_inst[30:25], in_inst[11:8],
                                 1'b0}));
      end
      is_u: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      is_j: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12],
                                 in_inst[20], in_inst[30:21],
                                 1'b0}));
      end
      is_z: begin
        dec_fmt = FMT_Z;
        dec_imm = XLEN'(in_inst[19:15]);
      end
      default: begin
        dec_fmt = FMT_NONE;
        dec_imm = '0;
      end
    endcase
  end

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_inst_d  = main_inst_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_inst_d  = skid_inst_q;
    if (!main_valid_q || (drain && !skid_valid_q)) begin
      main_valid_d = accept;
      if (accept) begin
        main_imm_d  = dec_imm;
        main_fmt_d  = dec_fmt;
        main_inst_d = in_inst;
      end
    end else if (drain) begin
      // Skid full here, so in_ready was low and nothing is accepted.
      main_valid_d = 1'b1;
      main_imm_d   = skid_imm_q;
      main_fmt_d   = skid_fmt_q;
      main_inst_d  = skid_inst_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_inst_d  = in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= '0;
      main_inst_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_inst_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_inst_q  <= main_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_fmt   = main_fmt_q;
  assign out_inst  = main_inst_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one
// input stream; directed decode vectors, backpressure, random flow, reset.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [31:0] out_inst32;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [31:0] out_inst64;

  int checks = 0;
  int errors = 0;
  logic [31:0] words[];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_inst(out_inst32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_inst(out_inst64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a later edge.
  task automatic send_one(input logic [31:0] inst,
                          input logic [31:0] i32,
                          input logic [2:0]  f32,
                          input logic [63:0] i64,
                          input logic [2:0]  f64);
    in_valid  = 1'b1;
    in_inst   = inst;
    out_ready = 1'b1;
    #1;
    chk("rdy32", in_ready32, 1);
    chk("rdy64", in_ready64, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ov32", out_valid32, 1);
    chk("imm32", out_imm32, i32);
    chk("fmt32", out_fmt32, f32);
    chk("inst32", out_inst32, inst);
    chk("ov64", out_valid64, 1);
    chk("imm64", out_imm64, i64);
    chk("fmt64", out_fmt64, f64);
    @(posedge clk); #1;
    chk("drained", out_valid32, 0);
  endtask

  task automatic stream(input int n, input bit rnd);
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    int cnt = 0;
    int last_drn = 0;
    bit acc, drn;
    words = new[n];
    for (int i = 0; i < n; i++)
      words[i] = rnd ? $urandom : (((i + 1) << 20) | 32'h13);
    while (rcv < n && cyc < n * 8 + 50) begin
      cyc++;
      in_valid = (sent < n) &&
                 (rnd ? ($urandom_range(3) != 0) : 1'b1);
      in_inst = in_valid ? words[sent] : 32'h0;
      out_ready = rnd ? ($urandom_range(3) != 0)
                      : !(cyc >= 2 && cyc <= 6);
      #1;
      chk("in_ready", in_ready32, cnt != 2);
      if (rnd) begin
        out_ready = !out_ready;
        #1;
        chk("ready_path", in_ready32, cnt != 2);
        out_ready = !out_ready;
      end
      if (!rnd && cyc == 3) chk("bp_full", in_ready32, 0);
      chk("occupied", out_valid32, cnt != 0);
      if (out_valid32) begin
        chk("order32", out_inst32, words[rcv]);
        if (!rnd) chk("bp_imm", out_imm32, rcv + 1);
      end
      if (out_valid64) chk("order64", out_inst64, words[rcv]);
      acc = in_valid && in_ready32;
      drn = out_valid32 && out_ready;
      if (drn) begin
        rcv++;
        last_drn = cyc;
      end
      if (acc) sent++;
      cnt = cnt + int'(acc) - int'(drn);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_done", rcv, n);
    if (!rnd) chk("last_drain", last_drn, 16);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid32, 0);
    chk("rst_ir", in_ready32, 0);
    chk("rst_imm", out_imm64, 0);
    chk("rst_fmt", out_fmt32, 0);
    chk("rst_inst", out_inst32, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ir", in_ready32, 1);
    @(posedge clk); #1;

    send_one(32'hFFF00093, 32'hFFFFFFFF, 3'd0,
             64'hFFFFFFFFFFFFFFFF, 3'd0);
    send_one(32'hFE112E23, 32'hFFFFFFFC, 3'd1,
             64'hFFFFFFFFFFFFFFFC, 3'd1);
    send_one(32'hFE000CE3, 32'hFFFFFFF8, 3'd2,
             64'hFFFFFFFFFFFFFFF8, 3'd2);
    send_one(32'h123452B7, 32'h12345000, 3'd3,
             64'h0000000012345000, 3'd3);
    send_one(32'h001000EF, 32'h00000800, 3'd4,
             64'h0000000000000800, 3'd4);
    send_one(32'h300FD073, 32'h0000001F, 3'd5,
             64'h000000000000001F, 3'd5);
    send_one(32'h30029073, 32'h00000300, 3'd0,
             64'h0000000000000300, 3'd0);
    send_one(32'h002081B3, 32'h0, 3'd7, 64'h0, 3'd7);
    send_one(32'h800002B7, 32'h80000000, 3'd3,
             64'hFFFFFFFF80000000, 3'd3);
    send_one(32'hFFF0809B, 32'h0, 3'd7,
             64'hFFFFFFFFFFFFFFFF, 3'd0);

    stream(10, 1'b0);
    stream(10000, 1'b1);

    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_inst   = 32'h00100093;
    @(posedge clk); #1;
    in_inst = 32'h00200093;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_ir", in_ready32, 0);
    chk("full_ov", out_valid32, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ir", in_ready32, 0);
    @(posedge clk); #1;
    chk("mid_rst_ov", out_valid32, 0);
    chk("mid_rst_ir2", in_ready64, 0);
    chk("mid_rst_imm", out_imm32, 0);
    chk("mid_rst_inst", out_inst64, 0);
    rst = 1'b0;
    #1;
    chk("after_rst_ir", in_ready32, 1);
    send_one(32'h00500093, 32'h5, 3'd0, 64'h5, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
